// File: rtl/dsp_lut_iq_loader.sv
// Loads a DEPTH-word IQ table into a LUT from a valid/ready word stream.
// Optional DSP_LUT_IQ_LOADER_SUM_EN adds a modulo-2^16 checksum that is checked before done.
module dsp_lut_iq_loader #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [OUT_WIDTH-2:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 lut_clr,
  output logic                 lut_wr,
  output logic [OUT_WIDTH-2:0] lut_data,
  output logic                 lut_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IN_WIDTH-1:0]  count,
`ifdef DSP_LUT_IQ_LOADER_SUM_EN
  input  logic [15:0]          sum_exp,
  output logic [15:0]          sum,
`endif
  output logic [1:0]           state_dbg
);

  localparam int DEPTH = 2 ** (IN_WIDTH - 1);
  localparam int W     = OUT_WIDTH - 1;
  localparam int IW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic                s_ready_d, lut_clr_d, lut_wr_d, lut_en_d, busy_d, done_d, err_d;
  logic [W-1:0]        lut_data_d;
  logic [IN_WIDTH-1:0] count_d;
  logic                hs;
  logic                sum_ok;

`ifdef DSP_LUT_IQ_LOADER_SUM_EN
  logic [15:0] sum_d;
  assign sum_ok = (sum == sum_exp);
`else
  assign sum_ok = 1'b1;
`endif

  // Handshake: a word is accepted on a rising edge where s_valid and s_ready are both
  // high. s_ready is high only in LOAD; a handshake in the same cycle as abort is still written.
  assign hs        = s_valid && s_ready;
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    s_ready_d  = 1'b0;
    lut_clr_d  = 1'b0;
    lut_wr_d   = 1'b0;
    lut_data_d = lut_data;
    lut_en_d   = lut_en;
    done_d     = 1'b0;
    err_d      = err;
    count_d    = count;
`ifdef DSP_LUT_IQ_LOADER_SUM_EN
    sum_d      = sum;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_CLEAR;
          lut_clr_d = 1'b1;
          count_d   = '0;
          err_d     = 1'b0;
          lut_en_d  = 1'b0;
`ifdef DSP_LUT_IQ_LOADER_SUM_EN
          sum_d     = '0;
`endif
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d  = ST_IDLE;
          lut_en_d = 1'b0;
        end else begin
          state_d   = ST_LOAD;
          s_ready_d = 1'b1;
          idle_d    = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          lut_wr_d   = 1'b1;
          lut_data_d = s_data;
          count_d    = count + 1'b1;
          idle_d     = '0;
`ifdef DSP_LUT_IQ_LOADER_SUM_EN
          sum_d      = sum + {{(16 - W){1'b0}}, s_data};
`endif
        end else begin
          idle_d = idle_q + 1'b1;
        end
        if (abort) begin
          state_d  = ST_IDLE;
          lut_en_d = 1'b0;
        end else if (hs && count == IN_WIDTH'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else if (!hs && idle_q == IW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          s_ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          lut_en_d = 1'b0;
        end else if (sum_ok) begin
          done_d   = 1'b1;
          lut_en_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idle_q   <= '0;
      s_ready  <= 1'b0;
      lut_clr  <= 1'b0;
      lut_wr   <= 1'b0;
      lut_data <= '0;
      lut_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
`ifdef DSP_LUT_IQ_LOADER_SUM_EN
      sum      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      s_ready  <= s_ready_d;
      lut_clr  <= lut_clr_d;
      lut_wr   <= lut_wr_d;
      lut_data <= lut_data_d;
      lut_en   <= lut_en_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      count    <= count_d;
`ifdef DSP_LUT_IQ_LOADER_SUM_EN
      sum      <= sum_d;
`endif
    end
  end

endmodule
